ball_velocity_gen: RTL and testbench

BALL_VELOCITY_GEN -- requirements
Module: ball_velocity_gen

---
 rtl/ball_rng_pkg.sv | 33 +++
 rtl/lfsr_core.sv | 48 ++++
 rtl/ball_velocity_gen.sv | 187 ++++++++++++++++++
 tb/tb_ball_velocity_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_rng_pkg.sv
// Shared types and LFSR tap constants for the ball velocity generator.
// Holds the draw FSM state enum and the X direction policy enum.
package ball_rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    DIR_RAND = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_ALT  = 2'b11
  } dir_e;

  localparam logic [7:0]  TAP8  = 8'hB8;
  localparam logic [15:0] TAP16 = 16'hB400;
  localparam logic [31:0] TAP32 = 32'hA300_0000;

  // Right-shifting Galois taps for each supported width.
  function automatic logic [31:0] lfsr_tap(input int w);
    logic [31:0] t;
    case (w)
      8:       t = {24'd0, TAP8};
      32:      t = TAP32;
      default: t = {16'd0, TAP16};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Parametrised right-shifting Galois LFSR with xor-in and zero guard.
// A zero next state is replaced by the seed (or 1 for a zero seed).
module lfsr_core
  import ball_rng_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAP  = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         xor_en_i,
  input  logic [7:0]   xor_i,
  output logic [W-1:0] state_o
);

  localparam logic [W-1:0] SEED_NZ =
    (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic [W-1:0] mix;

  function automatic logic [W-1:0] step(
    input logic [W-1:0] s
  );
    logic [W-1:0] n;
    n = {1'b0, s[W-1:1]};
    if (s[0]) n = n ^ TAP;
    return n;
  endfunction

  // Next state: one Galois step, optional xor-in, then zero guard.
  always_comb begin
    mix     = xor_en_i ? W'(xor_i) : '0;
    state_d = step(state_q) ^ mix;
    if (state_d == '0) state_d = SEED_NZ;
  end

  // State register, reloaded with the guarded seed on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SEED_NZ;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/ball_velocity_gen.sv
// Random signed X/Y ball velocity generator with rejection sampling.
// Define BALL_RNG_ENTROPY_EN to mix the entropy byte into the LFSR on each accepted request.
module ball_velocity_gen
  import ball_rng_pkg::*;
#(
  parameter int          LFSR_W    = 16,
  parameter int          SPEED_W   = 4,
  parameter int          MIN_SPEED = 1,
  parameter int          MAX_SPEED = 6,
  parameter logic [31:0] SEED      = 32'h0000_ACE1,
  parameter int          MAX_TRIES = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               req,
  input  logic               ack,
  input  logic [1:0]         dir_mode,
  input  logic [7:0]         entropy,
  output logic [SPEED_W-1:0] Xspeed,
  output logic [SPEED_W-1:0] Yspeed,
  output logic               valid,
  output logic               busy
);

  localparam int MW = SPEED_W - 1;
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [LFSR_W-1:0] TAP =
    LFSR_W'(lfsr_tap(LFSR_W));
  localparam logic [LFSR_W-1:0] SEED_L =
    LFSR_W'(SEED);

  localparam logic [SPEED_W-1:0] MIN_S =
    SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] MAX_S =
    SPEED_W'(MAX_SPEED);
  localparam logic [TW-1:0] LAST_TRY =
    TW'(MAX_TRIES - 1);

  state_e             state_q;
  logic               req_d;
  logic               valid_q;
  logic               busy_q;
  logic               xpos_q;
  logic [TW-1:0]      tries_q;
  logic [SPEED_W-1:0] xs_q;
  logic [SPEED_W-1:0] ys_q;

  logic [LFSR_W-1:0]  lfsr;
  logic               edge_ok;
  logic               mix_en;
  logic               unused_lfsr;

  logic [MW-1:0]      mag_x;
  logic [MW-1:0]      mag_y;
  logic [MW-1:0]      clp_x;
  logic [MW-1:0]      clp_y;
  logic               s_x;
  logic               s_y;
  logic               x_pos;
  logic               in_rng;
  logic               last_try;
  logic [SPEED_W-1:0] x_val;
  logic [SPEED_W-1:0] y_val;

  // Widened compare keeps range tests valid when MAX fills the field.
  function automatic logic in_range(
    input logic [MW-1:0] m
  );
    logic [SPEED_W-1:0] e;
    e = {1'b0, m};
    return (e >= MIN_S) && (e <= MAX_S);
  endfunction

  function automatic logic [MW-1:0] clamp(
    input logic [MW-1:0] m
  );
    logic [SPEED_W-1:0] e;
    e = {1'b0, m};
    if (e < MIN_S) e = MIN_S;
    if (e > MAX_S) e = MAX_S;
    return e[MW-1:0];
  endfunction

  function automatic logic [SPEED_W-1:0] apply_sign(
    input logic          pos,
    input logic [MW-1:0] m
  );
    logic [SPEED_W-1:0] v;
    v = {1'b0, m};
    return pos ? v : -v;
  endfunction

  assign edge_ok = (state_q == IDLE) & req & ~req_d;

`ifdef BALL_RNG_ENTROPY_EN
  assign mix_en = edge_ok;
`else
  assign mix_en = 1'b0;
`endif

  lfsr_core #(
    .W    (LFSR_W),
    .TAP  (TAP),
    .SEED (SEED_L)
  ) u_lfsr (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .xor_en_i (mix_en),
    .xor_i    (entropy),
    .state_o  (lfsr)
  );

  assign unused_lfsr = ^lfsr;

  // Candidate velocity from the current LFSR state.
  always_comb begin
    mag_x    = lfsr[MW-1:0];
    mag_y    = lfsr[2*MW-1:MW];
    s_x      = lfsr[LFSR_W-1];
    s_y      = lfsr[LFSR_W-2];
    in_rng   = in_range(mag_x) && in_range(mag_y);
    last_try = (tries_q == LAST_TRY);
    clp_x    = clamp(mag_x);
    clp_y    = clamp(mag_y);
    x_pos    = s_x;
    case (dir_e'(dir_mode))
      DIR_RAND: x_pos = s_x;
      DIR_POS:  x_pos = 1'b1;
      DIR_NEG:  x_pos = 1'b0;
      DIR_ALT:  x_pos = ~xpos_q;
      default:  x_pos = s_x;
    endcase
    x_val = apply_sign(x_pos, clp_x);
    y_val = apply_sign(s_y, clp_y);
  end

  // Request / draw / hold FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      req_d   <= 1'b0;
      tries_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      xs_q    <= MIN_S;
      ys_q    <= MIN_S;
      xpos_q  <= 1'b1;
    end else begin
      req_d <= req;
      unique case (state_q)
        IDLE: begin
          if (edge_ok) begin
            state_q <= DRAW;
            busy_q  <= 1'b1;
            tries_q <= '0;
          end
        end
        DRAW: begin
          if (in_rng || last_try) begin
            xs_q    <= x_val;
            ys_q    <= y_val;
            xpos_q  <= x_pos;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            tries_q <= tries_q + TW'(1);
          end
        end
        HOLD: begin
          if (ack) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Xspeed = xs_q;
  assign Yspeed = ys_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ball_velocity_gen.sv
// Bench for ball_velocity_gen: predicted draws checked by a monitor,
// plus directed clamp, zero-seed, alternate-sign and reset checks.
`timescale 1ns/1ps
module tb_ball_velocity_gen;

  typedef struct {
    logic signed [3:0] x;
    logic signed [3:0] y;
    logic              xpos;
    int                lat;
    int                ecyc;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic clk    = 1'b0;

  always #5 clk = ~clk;

  logic       rst, req, ack;
  logic [1:0] dir;
  logic [7:0] ent0 = 8'h00;
  logic [3:0] xs, ys;
  logic       vld, bsy;

  logic       rst_c, req_c, ack_c;
  logic [3:0] xs_c, ys_c;
  logic       vld_c, bsy_c;

  logic       rst_z, req_z, ack_z;
  logic [3:0] xs_z, ys_z;
  logic       vld_z, bsy_z;

  ball_velocity_gen dut (
    .CLK(clk), .RESET(rst), .req(req), .ack(ack),
    .dir_mode(dir), .entropy(ent0),
    .Xspeed(xs), .Yspeed(ys), .valid(vld), .busy(bsy)
  );

  ball_velocity_gen #(
    .MIN_SPEED(7), .MAX_SPEED(7), .MAX_TRIES(1)
  ) dut_c (
    .CLK(clk), .RESET(rst_c), .req(req_c), .ack(ack_c),
    .dir_mode(dir), .entropy(ent0),
    .Xspeed(xs_c), .Yspeed(ys_c), .valid(vld_c), .busy(bsy_c)
  );

  ball_velocity_gen #(.SEED(0)) dut_z (
    .CLK(clk), .RESET(rst_z), .req(req_z), .ack(ack_z),
    .dir_mode(dir), .entropy(ent0),
    .Xspeed(xs_z), .Yspeed(ys_z), .valid(vld_z), .busy(bsy_z)
  );

`ifdef BALL_RNG_ENTROPY_EN
  logic [7:0] ent5 = 8'h5A;
  logic [3:0] xs_e, ys_e;
  logic       vld_e, bsy_e;
  ball_velocity_gen dut_e (
    .CLK(clk), .RESET(rst), .req(req), .ack(ack),
    .dir_mode(dir), .entropy(ent5),
    .Xspeed(xs_e), .Yspeed(ys_e), .valid(vld_e), .busy(bsy_e)
  );
`endif

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // Reference LFSR: 16-bit right-shift Galois, taps B400.
  function automatic logic [15:0] mstep(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    if (n == 16'h0) n = 16'hACE1;
    return n;
  endfunction

  function automatic bit okm(input logic [2:0] v);
    return (v >= 3'd1) && (v <= 3'd6);
  endfunction

  function automatic logic signed [3:0] sgn(input bit pos,
                                           input logic [2:0] m);
    logic signed [3:0] v;
    v = $signed({1'b0, m});
    return pos ? v : -v;
  endfunction

  function automatic int mag4(input logic [3:0] v);
    int s;
    s = $signed(v);
    return (s < 0) ? -s : s;
  endfunction

  // Expected draw for default parameters given the edge-cycle LFSR.
  function automatic exp_t predict(input logic [15:0] cur,
                                   input logic [1:0] dm,
                                   input logic ppos,
                                   input int ecyc);
    exp_t e;
    logic [15:0] v;
    logic [2:0] mx, my;
    int n;
    v = mstep(cur);
    n = 1;
    while (!(okm(v[2:0]) && okm(v[5:3])) && n < 4) begin
      v = mstep(v);
      n++;
    end
    mx = v[2:0];
    my = v[5:3];
    if (mx == 3'd0) mx = 3'd1;
    if (mx == 3'd7) mx = 3'd6;
    if (my == 3'd0) my = 3'd1;
    if (my == 3'd7) my = 3'd6;
    case (dm)
      2'b00:   e.xpos = v[15];
      2'b01:   e.xpos = 1'b1;
      2'b10:   e.xpos = 1'b0;
      default: e.xpos = !ppos;
    endcase
    e.x    = sgn(e.xpos, mx);
    e.y    = sgn(v[14], my);
    e.lat  = n + 1;
    e.ecyc = ecyc;
    return e;
  endfunction

  logic [15:0] m;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m   <= rst ? 16'hACE1 : mstep(m);
  end

  exp_t q[$];
  exp_t last;
  logic vld_prev = 1'b0;
  logic mprev    = 1'b1;

  // Monitor: compare each fresh valid against the oldest prediction.
  always @(negedge clk) begin
    if (vld && !vld_prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1, expected no draw");
      end else begin
        last = q.pop_front();
        chk("x_speed", $signed(xs), last.x);
        chk("y_speed", $signed(ys), last.y);
        chk("latency", cyc - last.ecyc, last.lat);
      end
    end
    vld_prev = vld;
  end

  task automatic do_draw(input logic [1:0] dm, output exp_t e);
    int t;
    @(negedge clk);
    dir = dm;
    req = 1'b1;
    e = predict(m, dm, mprev, cyc);
    q.push_back(e);
    mprev = e.xpos;
    @(negedge clk);
    req = 1'b0;
    chk("busy_in_draw", bsy, 1);
    t = 0;
    while (!vld && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("valid_seen", vld, 1);
  endtask

  task automatic do_ack(input exp_t e);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("valid_after_ack", vld, 0);
    chk("busy_after_ack", bsy, 0);
    chk("x_retained", $signed(xs), e.x);
    chk("y_retained", $signed(ys), e.y);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    mprev = 1'b1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   nbad;
    rst = 1; rst_c = 1; rst_z = 1;
    req = 0; req_c = 0; req_z = 0;
    ack = 0; ack_c = 0; ack_z = 0;
    dir = 2'b01;
    repeat (2) @(negedge clk);
    chk("rst_x", $signed(xs), 1);
    chk("rst_y", $signed(ys), 1);
    chk("rst_valid", vld, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_lfsr", dut.lfsr, 16'hACE1);
    chk("rst_x_clamp", $signed(xs_c), 7);
    chk("zero_seed_lfsr", dut_z.lfsr, 1);
    rst = 0; rst_c = 0; rst_z = 0;
    mprev = 1'b1;
    @(negedge clk);
    chk("lfsr_step1", dut.lfsr, 16'hE270);
    chk("zero_seed_step1", dut_z.lfsr, 16'hB400);
    @(negedge clk);
    chk("lfsr_step2", dut.lfsr, 16'h7138);

    // Single draw, forced positive, held 100 cycles with a stray edge.
    do_draw(2'b01, e);
`ifdef BALL_RNG_ENTROPY_EN
    chk("entropy_diverge", dut_e.lfsr != dut.lfsr, 1);
`endif
    chk("x_pos_range", ($signed(xs) >= 1) && ($signed(xs) <= 6), 1);
    chk("y_mag_range", (mag4(ys) >= 1) && (mag4(ys) <= 6), 1);
    nbad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) req = 1'b1;
      if (i == 12) req = 1'b0;
      @(negedge clk);
      if (vld !== 1'b1 || bsy !== 1'b1 ||
          $signed(xs) != e.x || $signed(ys) != e.y)
        nbad++;
    end
    chk("hold_stable_100", nbad, 0);
    do_ack(e);
    repeat (4) @(negedge clk);
    chk("second_edge_ignored", bsy, 0);

    // ack outside HOLD has no effect.
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    chk("ack_idle_busy", bsy, 0);
    chk("ack_idle_valid", vld, 0);

    for (int i = 0; i < 4; i++) begin
      do_draw(2'b00, e);
      do_ack(e);
    end
    for (int i = 0; i < 3; i++) begin
      do_draw(2'b10, e);
      chk("neg_sign", xs[3], 1);
      do_ack(e);
    end

    // Clamp instance: every draw forced to magnitude 7.
    dir = 2'b01;
    @(negedge clk);
    req_c = 1'b1;
    @(negedge clk);
    req_c = 1'b0;
    chk("clamp_valid_e1", vld_c, 0);
    chk("clamp_busy_e1", bsy_c, 1);
    @(negedge clk);
    chk("clamp_valid_e2", vld_c, 1);
    chk("clamp_x_pos", $signed(xs_c), 7);
    chk("clamp_y_mag", mag4(ys_c), 7);
    ack_c = 1'b1;
    @(negedge clk);
    ack_c = 1'b0;
    dir = 2'b10;
    @(negedge clk);
    req_c = 1'b1;
    @(negedge clk);
    req_c = 1'b0;
    @(negedge clk);
    chk("clamp2_valid_e2", vld_c, 1);
    chk("clamp_x_neg", $signed(xs_c), -7);
    chk("clamp2_y_mag", mag4(ys_c), 7);
    ack_c = 1'b1;
    @(negedge clk);
    ack_c = 1'b0;

    // Alternate mode from reset: first round negative.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_draw(2'b11, e);
      chk("alt_sign", xs[3], (i % 2 == 0) ? 1 : 0);
      do_ack(e);
    end

    // Reset while holding a draw.
    do_draw(2'b00, e);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_valid", vld, 0);
    chk("rst_hold_busy", bsy, 0);
    rst = 1'b0;
    q.delete();
    mprev = 1'b1;
    nbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (vld) nbad++;
    end
    chk("no_valid_after_hold_rst", nbad, 0);

    // Reset while drawing.
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_draw_busy", bsy, 0);
    nbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (vld || bsy) nbad++;
    end
    chk("no_valid_after_draw_rst", nbad, 0);

    // Zero-seed instance never reaches the all-zero state.
    nbad = 0;
    repeat (200) begin
      @(negedge clk);
      if (dut_z.lfsr == 16'h0) nbad++;
    end
    chk("zero_seed_never0", nbad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
